// File: rtl/alu_exec_unit_if.sv
// ============================================================================
// Module  : alu_exec_unit_if
// Purpose : Operation and result handshake bundle between the ALU decoder
//           (master) and the execute-stage ALU (slave).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alucontrol;
    logic             shift;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic [4:0]       shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;

    modport master (
        output in_valid, alucontrol, shift, srca, srcb, shamt, out_ready,
        input  in_ready, out_valid, result, zero, ovf
    );

    modport slave (
        input  in_valid, alucontrol, shift, srca, srcb, shamt, out_ready,
        output in_ready, out_valid, result, zero, ovf
    );
endinterface

`default_nettype wire

// File: rtl/alu_exec_unit.sv
// ============================================================================
// Module  : alu_exec_unit
// Purpose : Execute-stage ALU: single-cycle logic/arith ops, iterative
//           shifts of up to SHIFT_STEP bits per cycle. Optional macro
//           ALU_OVF_EN enables registered signed-overflow on add/sub.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_exec_unit #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          flush,
    alu_exec_unit_if.slave     bus
);

    localparam int              SHW    = $clog2(WIDTH);
    localparam logic [SHW-1:0]  STEP_C = SHW'(SHIFT_STEP);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  work_q;
    logic [SHW-1:0]    rem_q;
    logic [1:0]        kind_q;
    logic [WIDTH-1:0]  result_q;
    logic              zero_q;
    logic              out_valid_q;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_consume;
    logic              w_is_shift;
    logic [SHW-1:0]    w_amt;
    logic [WIDTH-1:0]  w_sum;
    logic [WIDTH-1:0]  w_diff;
    logic [WIDTH-1:0]  w_imm;
    logic [SHW-1:0]    w_step;
    logic              w_last;
    logic [WIDTH-1:0]  w_work_d;

    assign w_in_ready = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_consume  = out_valid_q && bus.out_ready;

    assign w_is_shift = (bus.alucontrol == 3'b011) || (bus.alucontrol == 3'b100) ||
                        (bus.alucontrol == 3'b101);
    assign w_amt      = bus.shift ? bus.shamt[SHW-1:0] : bus.srca[SHW-1:0];

    assign w_sum  = bus.srca + bus.srcb;
    assign w_diff = bus.srca - bus.srcb;

    // Shifts by zero fall through here and return srcb unchanged.
    always_comb begin
        w_imm = bus.srcb;
        case (bus.alucontrol)
            3'b000:  w_imm = bus.srca & bus.srcb;
            3'b001:  w_imm = bus.srca | bus.srcb;
            3'b010:  w_imm = w_sum;
            3'b110:  w_imm = w_diff;
            3'b111:  w_imm = {{(WIDTH-1){1'b0}}, ($signed(bus.srca) < $signed(bus.srcb))};
            default: w_imm = bus.srcb;
        endcase
    end

`ifdef ALU_OVF_EN
    logic ovf_q;
    logic w_ovf;

    always_comb begin
        w_ovf = 1'b0;
        case (bus.alucontrol)
            3'b010:  w_ovf = (bus.srca[WIDTH-1] == bus.srcb[WIDTH-1]) &&
                             (w_sum[WIDTH-1]  != bus.srca[WIDTH-1]);
            3'b110:  w_ovf = (bus.srca[WIDTH-1] != bus.srcb[WIDTH-1]) &&
                             (w_diff[WIDTH-1] != bus.srca[WIDTH-1]);
            default: w_ovf = 1'b0;
        endcase
    end
`endif

    assign w_step = (rem_q > STEP_C) ? STEP_C : rem_q;
    assign w_last = (rem_q <= STEP_C);

    // kind_q keeps alucontrol[1:0]: 11 sll, 01 srl, 00 sra.
    always_comb begin
        w_work_d = work_q;
        case (kind_q)
            2'b11:   w_work_d = work_q << w_step;
            2'b01:   w_work_d = work_q >> w_step;
            default: w_work_d = $signed(work_q) >>> w_step;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            work_q      <= '0;
            rem_q       <= '0;
            kind_q      <= 2'b00;
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef ALU_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else if (flush) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_consume) begin
                        out_valid_q <= 1'b0;
                    end
                    if (w_accept) begin
                        if (w_is_shift && (w_amt != '0)) begin
                            work_q  <= bus.srcb;
                            rem_q   <= w_amt;
                            kind_q  <= bus.alucontrol[1:0];
                            state_q <= S_SHIFT;
                        end else begin
                            result_q    <= w_imm;
                            zero_q      <= (w_imm == '0);
                            out_valid_q <= 1'b1;
`ifdef ALU_OVF_EN
                            ovf_q       <= w_ovf;
`endif
                        end
                    end
                end
                S_SHIFT: begin
                    work_q <= w_work_d;
                    rem_q  <= rem_q - w_step;
                    if (w_last) begin
                        result_q    <= w_work_d;
                        zero_q      <= (w_work_d == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= S_IDLE;
`ifdef ALU_OVF_EN
                        ovf_q       <= 1'b0;
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
`ifdef ALU_OVF_EN
    assign bus.ovf       = ovf_q;
`else
    assign bus.ovf       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// ============================================================================
// Module  : tb_alu_exec_unit
// Purpose : Scoreboard bench for alu_exec_unit: directed scenarios followed
//           by randomized operations against an arithmetic reference model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_exec_unit;

    localparam int WIDTH      = 32;
    localparam int SHIFT_STEP = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    always #5 clk = ~clk;

    alu_exec_unit_if #(.WIDTH(WIDTH)) bus ();

    alu_exec_unit #(
        .WIDTH      (WIDTH),
        .SHIFT_STEP (SHIFT_STEP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   rand_or  = 0;
    bit   presented = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: results from plain integer arithmetic on the op's definition.
    function automatic exp_t model(input logic [2:0] ac, input bit sh,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] sa);
        exp_t        e;
        longint      la;
        longint      lb;
        longint      r;
        int          n;
        logic signed [31:0] bs;
        la    = longint'($signed(a));
        lb    = longint'($signed(b));
        bs    = b;
        n     = 0;
        e.ovf = 1'b0;
        e.lat = 1;
        e.acc_cyc = 0;
        case (ac)
            3'b000: e.res = a & b;
            3'b001: e.res = a | b;
            3'b010: begin
                r = la + lb;
                e.res = 32'(r);
                e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            3'b110: begin
                r = la - lb;
                e.res = 32'(r);
                e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            3'b111: e.res = (la < lb) ? 32'd1 : 32'd0;
            default: begin
                n = sh ? int'(sa) : int'(a[4:0]);
                if (ac == 3'b011)      e.res = b << n;
                else if (ac == 3'b101) e.res = b >> n;
                else                   e.res = bs >>> n;
                e.lat = (n == 0) ? 1 : (n + SHIFT_STEP - 1) / SHIFT_STEP + 1;
            end
        endcase
`ifndef ALU_OVF_EN
        e.ovf = 1'b0;
`endif
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    // Monitor: compare each result the first cycle it is presented.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || !bus.out_valid) begin
            presented = 0;
        end else if (!presented) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out_valid: got result 0x%0h expected no result", bus.result);
            end else begin
                e = sb.pop_front();
                chk ("result",  bus.result, e.res);
                chkb("zero",    bus.zero,   e.zero);
                chkb("ovf",     bus.ovf,    e.ovf);
                chk ("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
            end
            presented = 1;
        end
        if (bus.out_valid && bus.out_ready) presented = 0;
    end

    task automatic issue(input logic [2:0] ac, input bit sh, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sa, output int waits);
        exp_t e;
        bit   accepted;
        e = model(ac, sh, a, b, sa);
        bus.alucontrol = ac;
        bus.shift      = sh;
        bus.srca       = a;
        bus.srcb       = b;
        bus.shamt      = sa;
        bus.in_valid   = 1'b1;
        waits    = 0;
        accepted = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (bus.in_ready && !flush && rst_n) begin
                e.acc_cyc = cyc;
                sb.push_back(e);
                accepted = 1;
                break;
            end
            waits++;
            @(posedge clk); #1;
            if (rand_or) bus.out_ready = 1'($urandom_range(0, 1));
        end
        if (!accepted) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got no accept expected accept within 300 cycles");
        end
        @(posedge clk); #1;
        bus.in_valid   = 1'b0;
        bus.srca       = $urandom;
        bus.srcb       = $urandom;
        bus.shamt      = 5'($urandom);
        bus.shift      = 1'($urandom);
        bus.alucontrol = 3'($urandom);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 200; t++) begin
            @(posedge clk); #1;
            if (sb.size() == 0) break;
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corners [5];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'h7FFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int low;
        bus.in_valid   = 1'b0;
        bus.alucontrol = 3'b000;
        bus.shift      = 1'b0;
        bus.srca       = '0;
        bus.srcb       = '0;
        bus.shamt      = '0;
        bus.out_ready  = 1'b1;
        flush          = 1'b0;
        rst_n          = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chkb("rst_out_valid", bus.out_valid, 1'b0);
        chk ("rst_result",    bus.result,    32'h0);
        chkb("rst_zero",      bus.zero,      1'b1);
        chkb("rst_ovf",       bus.ovf,       1'b0);
        chkb("rst_in_ready",  bus.in_ready,  1'b1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Signed overflow on add.
        issue(3'b010, 1'b0, 32'h7FFF_FFFF, 32'h1, 5'd0, w);
        wait_idle();

        // Back-to-back single-cycle ops.
        issue(3'b110, 1'b0, 32'd5, 32'd5, 5'd0, w);
        issue(3'b111, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd0, w);
        chk("b2b_waits", 32'(w), 32'd0);
        wait_idle();

        // Long arithmetic shift right: busy for ceil(31/4) cycles.
        issue(3'b100, 1'b1, 32'h0, 32'h8000_0000, 5'd31, w);
        low = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus.in_ready) break;
            low++;
        end
        chk("sra_busy_cycles", 32'(low), 32'd8);
        wait_idle();

        // Variable srl, amount taken from srca[4:0].
        issue(3'b101, 1'b0, 32'h25, 32'hF0, 5'd3, w);
        wait_idle();
        issue(3'b101, 1'b0, 32'h20, 32'hF0, 5'd3, w);
        wait_idle();

        // Backpressure: held result, then consume-and-load on the same edge.
        bus.out_ready = 1'b0;
        issue(3'b001, 1'b0, 32'h1234, 32'h8000, 5'd0, w);
        bus.alucontrol = 3'b010;
        bus.shift      = 1'b0;
        bus.srca       = 32'd3;
        bus.srcb       = 32'd4;
        bus.in_valid   = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chkb("bp_in_ready",  bus.in_ready,  1'b0);
            chkb("bp_out_valid", bus.out_valid, 1'b1);
            chk ("bp_hold",      bus.result,    32'h9234);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        issue(3'b010, 1'b0, 32'd3, 32'd4, 5'd0, w);
        chk("bp_release_waits", 32'(w), 32'd0);
        wait_idle();

        // Flush two cycles into an sll by 20.
        issue(3'b011, 1'b1, 32'h0, 32'h1, 5'd20, w);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        chkb("flush_out_valid", bus.out_valid, 1'b0);
        chkb("flush_in_ready",  bus.in_ready,  1'b1);
        repeat (8) @(negedge clk);
        chkb("flush_no_result", bus.out_valid, 1'b0);

        // in_valid on a flush edge while idle must not be accepted.
        @(posedge clk); #1;
        bus.alucontrol = 3'b001;
        bus.srca       = 32'h5;
        bus.srcb       = 32'h0;
        bus.in_valid   = 1'b1;
        flush          = 1'b1;
        @(posedge clk); #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chkb("flush_no_accept", bus.out_valid, 1'b0);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a shift.
        issue(3'b001, 1'b0, 32'hA5, 32'h0, 5'd0, w);
        wait_idle();
        issue(3'b011, 1'b1, 32'h0, 32'h3, 5'd28, w);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chkb("arst_out_valid", bus.out_valid, 1'b0);
        chk ("arst_result",    bus.result,    32'h0);
        chkb("arst_zero",      bus.zero,      1'b1);
        chkb("arst_ovf",       bus.ovf,       1'b0);
        chkb("arst_in_ready",  bus.in_ready,  1'b1);
        sb.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic with random backpressure.
        rand_or = 1;
        for (int i = 0; i < 300; i++) begin
            issue(3'($urandom_range(0, 7)), 1'($urandom), pick(), pick(),
                  5'($urandom_range(0, 31)), w);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                bus.out_ready = 1'($urandom_range(0, 1));
            end
        end
        rand_or       = 0;
        bus.out_ready = 1'b1;
        wait_idle();
        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU for the pipelined MIPS core; the consumer end of the alucontrol/shift interface driven by the ALU decoder.
- Performs AND/OR/ADD/SUB/SLT in one cycle; performs SLL/SRL/SRA (immediate or variable amount) iteratively, SHIFT_STEP bits per cycle.
- Valid/ready handshakes on both sides; stalls the ID/EX stage while a shift is in progress.

Parameters:
- WIDTH, 32, datapath width; shift amount width is clog2(WIDTH).
- SHIFT_STEP, 4, maximum bit positions shifted per cycle; legal range 1..WIDTH/2.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of the in-flight op and the held result
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept an operation this cycle
- alucontrol  in  3  000 and, 001 or, 010 add, 110 sub, 111 slt, 011 sll, 100 sra, 101 srl
- shift  in  1  1 = amount from shamt; 0 = amount from srca[4:0] (variable shift)
- srca  in  WIDTH  operand A
- srcb  in  WIDTH  operand B; this is the shifted operand for shifts
- shamt  in  5  immediate shift amount
- out_valid  out  1  result held
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  registered result
- zero  out  1  result == 0, registered with result
- ovf  out  1  signed overflow of add/sub (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; out_valid=0, result=0, zero=1, ovf=0; remaining count 0. Reset mid-shift abandons the shift.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Combinational; no path from in_valid.
- Accept = in_valid && in_ready at a rising edge.
- Shift ops are alucontrol 011, 100, 101. shift is ignored for all other codes.
- Non-shift op, or shift op with amount 0: result, zero and ovf are registered on the accept edge; out_valid=1 after that edge. Latency is 1.
- and/or are bitwise. add/sub wrap modulo 2^WIDTH. slt gives result = {0..,1} when signed srca < signed srcb, else 0.
- Shift op with amount N>0:
  - Accept edge loads work=srcb and rem=N; state becomes SHIFT.
  - Each SHIFT edge shifts work by min(SHIFT_STEP, rem) and decrements rem by the same amount.
  - sll fills zeros. srl fills zeros. sra fills with work[WIDTH-1].
  - On the edge where rem<=SHIFT_STEP, the final value goes to result, zero is updated, out_valid=1, and state returns to IDLE.
  - Latency is ceil(N/SHIFT_STEP)+1 cycles. ovf=0 for shifts.
- out_valid and the result registers hold until out_valid && out_ready. Downstream consumes the result on that edge.
- A new result may load on the same edge that the old one is consumed (back-to-back single-cycle ops give 1 result per cycle).
- A consume edge without a new load clears out_valid. result keeps its last value.
- flush (priority below reset, above everything else): state becomes IDLE, out_valid=0, rem=0. in_valid is ignored on a flush edge; no accept occurs.
- Operands are sampled only at accept. Input changes during SHIFT have no effect.

Optional Feature:
- Macro ALU_OVF_EN.
- Defined: for add/sub, ovf is registered as signed overflow: operand signs equal (add) or differ (sub), and the result sign differs from srca. ovf is 0 for all other ops.
- Undefined: ovf is constant 0 and the overflow logic is absent. The port is still present.

Test Plan:
- Reset, then add srca=0x7FFFFFFF, srcb=1, out_ready=1 -> one cycle later result=0x80000000, zero=0, ovf=1 with ALU_OVF_EN (0 without).
- Back-to-back: sub 5-5 then slt -1<1 on consecutive cycles, out_ready=1 -> in_ready stays 1; results 0 (zero=1) then 1 on consecutive cycles.
- sra srcb=0x80000000, shift=1, shamt=31, SHIFT_STEP=4 -> in_ready low for 8 cycles; result=0xFFFFFFFF 9 cycles after accept.
- Variable srl: srca=0x25 (amount 5), srcb=0xF0, shift=0 -> result=0x7 after latency 3. Same op with srca=0x20 (amount 0) -> result=0xF0 after latency 1.
- Backpressure: out_ready=0 with in_valid held -> result holds, in_ready=0. Raising out_ready -> old result consumed and the next op accepted on the same edge.
- flush asserted 2 cycles into an sll by 20 -> out_valid stays 0 and in_ready=1 next cycle. rst_n pulsed low mid-shift -> outputs return to reset values immediately.
